// File: rtl/push_button_conditioner.sv
// Synchronises, debounces and edge-detects four push buttons, and encodes the latest press as a direction.
// Level, press pulse and direction strobe all land SYNC_STAGES + DEBOUNCE_CYCLES edges after a stable input change.
module push_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNTER_WIDTH   = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BUTTONS_IN,
  output logic [3:0] BUTTONS_LEVEL,
  output logic [3:0] BUTTONS_PRESS,
  output logic [1:0] DIRECTION,
  output logic       DIRECTION_VALID
);
  localparam int                       LAST    = SYNC_STAGES - 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][3:0]   sync_q, sync_d;
  logic [3:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]                    level_q, level_d;
  logic [3:0]                    press_q, press_d;
  logic [1:0]                    dir_q, dir_d;
  logic                          dir_vld_q, dir_vld_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], BUTTONS_IN};
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_q[LAST][i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // Press and direction are derived from level_d so all three change on the same edge.
    press_d   = level_d & ~level_q;
    dir_vld_d = |press_d;
    dir_d     = dir_q;
    for (int i = 3; i >= 0; i--) begin
      if (press_d[i]) begin
        dir_d = 2'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      dir_q     <= '0;
      dir_vld_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
    end
  end

  assign BUTTONS_LEVEL   = level_q;
  assign BUTTONS_PRESS   = press_q;
  assign DIRECTION       = dir_q;
  assign DIRECTION_VALID = dir_vld_q;
endmodule

// File: tb/tb_push_button_conditioner.sv
// Bench for push_button_conditioner: directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_push_button_conditioner;
  localparam int S = 2;
  localparam int D = 4;

  logic       CLK;
  logic       RESET;
  logic [3:0] BUTTONS_IN;
  logic [3:0] BUTTONS_LEVEL;
  logic [3:0] BUTTONS_PRESS;
  logic [1:0] DIRECTION;
  logic       DIRECTION_VALID;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int press_cnt = 0;

  push_button_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .COUNTER_WIDTH  (3)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BUTTONS_IN     (BUTTONS_IN),
    .BUTTONS_LEVEL  (BUTTONS_LEVEL),
    .BUTTONS_PRESS  (BUTTONS_PRESS),
    .DIRECTION      (DIRECTION),
    .DIRECTION_VALID(DIRECTION_VALID)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model: synchronised value is the input delayed S edges; a level
  // flips once the synchronised value has disagreed with it for D edges in a row.
  logic [3:0] m_pipe[$];
  int         m_run[4];
  logic [3:0] m_level = '0;
  logic [3:0] m_press = '0;
  logic [1:0] m_dir   = '0;
  logic       m_vld   = 1'b0;
  bit         m_ok    = 1'b0;

  always @(posedge CLK) begin
    logic [3:0] seen;
    logic [3:0] nxt;
    if (RESET) begin
      m_pipe = {};
      for (int k = 0; k < S; k++) m_pipe.push_back(4'b0000);
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_level = '0;
      m_press = '0;
      m_dir   = '0;
      m_vld   = 1'b0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      seen = m_pipe.pop_front();
      m_pipe.push_back(BUTTONS_IN);
      nxt = m_level;
      for (int k = 0; k < 4; k++) begin
        m_run[k] = (seen[k] != m_level[k]) ? m_run[k] + 1 : 0;
        if (m_run[k] == D) begin
          nxt[k]   = ~m_level[k];
          m_run[k] = 0;
        end
      end
      m_press = nxt & ~m_level;
      m_vld   = (m_press != 4'b0000);
      for (int k = 3; k >= 0; k--) if (m_press[k]) m_dir = 2'(k);
      m_level = nxt;
    end
  end

  always @(negedge CLK) begin
    if (m_ok) begin
      tests++;
      if ({BUTTONS_LEVEL, BUTTONS_PRESS, DIRECTION, DIRECTION_VALID} !==
          {m_level, m_press, m_dir, m_vld}) begin
        fails++;
        $display("FAIL model_cmp t=%0t: got level=%b press=%b dir=%0d vld=%b, expected level=%b press=%b dir=%0d vld=%b",
                 $time, BUTTONS_LEVEL, BUTTONS_PRESS, DIRECTION, DIRECTION_VALID,
                 m_level, m_press, m_dir, m_vld);
      end
    end
    if (DIRECTION_VALID === 1'b1) vld_cnt++;
    if (BUTTONS_PRESS !== 4'b0000) press_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [1:0] dir, input logic vld);
    chk({name, "_level"}, 8'(BUTTONS_LEVEL), 8'(lvl));
    chk({name, "_press"}, 8'(BUTTONS_PRESS), 8'(prs));
    chk({name, "_dir"},   8'(DIRECTION),     8'(dir));
    chk({name, "_vld"},   8'(DIRECTION_VALID), 8'(vld));
  endtask

  initial begin
    int v0;
    int p0;
    int hold;

    // Reset with all buttons held.
    RESET      = 1'b1;
    BUTTONS_IN = 4'b1111;
    step(2);
    chk_all("reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
    RESET = 1'b0;
    step(5);
    chk("held_thru_reset_early", 8'(BUTTONS_LEVEL), 8'h00);
    step(1);
    chk_all("held_thru_reset", 4'b1111, 4'b1111, 2'd0, 1'b1);
    step(1);
    chk_all("held_thru_reset_after", 4'b1111, 4'b0000, 2'd0, 1'b0);

    // Release everything, then a clean press on bit 2.
    BUTTONS_IN = 4'b0000;
    step(10);
    chk_all("release_all", 4'b0000, 4'b0000, 2'd0, 1'b0);
    BUTTONS_IN = 4'b0100;
    step(5);
    chk("clean_early", 8'(BUTTONS_LEVEL), 8'h00);
    step(1);
    chk_all("clean_press", 4'b0100, 4'b0100, 2'd2, 1'b1);
    step(10);
    chk_all("clean_hold", 4'b0100, 4'b0000, 2'd2, 1'b0);
    step(4);
    BUTTONS_IN = 4'b0000;
    step(10);

    // Bounce on bit 1: 3-cycle highs never survive debounce.
    v0 = vld_cnt;
    p0 = press_cnt;
    for (int r = 0; r < 2; r++) begin
      BUTTONS_IN = 4'b0010;
      step(3);
      BUTTONS_IN = 4'b0000;
      step(3);
    end
    step(2);
    chk("bounce_no_level", 8'(BUTTONS_LEVEL), 8'h00);
    chk("bounce_no_press", 8'(press_cnt - p0), 8'd0);
    BUTTONS_IN = 4'b0010;
    step(5);
    chk("bounce_early", 8'(BUTTONS_LEVEL), 8'h00);
    step(1);
    chk_all("bounce_settle", 4'b0010, 4'b0010, 2'd1, 1'b1);
    step(10);
    chk("bounce_one_strobe", 8'(vld_cnt - v0), 8'd1);
    BUTTONS_IN = 4'b0000;
    step(10);

    // Simultaneous press of bits 1 and 3.
    v0 = vld_cnt;
    BUTTONS_IN = 4'b1010;
    step(6);
    chk_all("simul", 4'b1010, 4'b1010, 2'd1, 1'b1);
    step(10);
    chk("simul_one_strobe", 8'(vld_cnt - v0), 8'd1);
    chk("simul_dir_held", 8'(DIRECTION), 8'd1);
    BUTTONS_IN = 4'b0000;
    step(10);

    // Long hold then release on bit 3.
    v0 = vld_cnt;
    p0 = press_cnt;
    BUTTONS_IN = 4'b1000;
    step(50);
    chk("hold_one_press", 8'(press_cnt - p0), 8'd1);
    BUTTONS_IN = 4'b0000;
    step(5);
    chk("release_early", 8'(BUTTONS_LEVEL), 8'h08);
    step(1);
    chk_all("release_fall", 4'b0000, 4'b0000, 2'd3, 1'b0);
    step(5);
    chk("release_no_strobe", 8'(vld_cnt - v0), 8'd1);

    // Reset in the middle of debouncing bit 0.
    BUTTONS_IN = 4'b0001;
    step(3);
    RESET = 1'b1;
    step(1);
    chk_all("mid_reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
    RESET = 1'b0;
    step(5);
    chk("mid_reset_early", 8'(BUTTONS_LEVEL), 8'h00);
    step(1);
    chk_all("mid_reset_press", 4'b0001, 4'b0001, 2'd0, 1'b1);
    step(2);

    // Randomized run: mixed glitch-length and stable holds with rare resets.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        BUTTONS_IN = 4'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      RESET = ($urandom_range(0, 299) == 0);
      step(1);
    end
    RESET = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
